// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and sizing helper for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Decimal digits needed to represent the largest bin_w-bit unsigned value.
  function automatic int unsigned min_digits(input int unsigned bin_w);
    longint unsigned max_val;
    int unsigned     n;
    max_val = (64'd1 << bin_w) - 64'd1;
    n       = 1;
    for (int i = 0; i < 20; i++) begin
      if (max_val >= 64'd10) begin
        max_val = max_val / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the left shift.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);

  assign d_o = (d_i >= DIGIT_W'(5)) ? d_i + DIGIT_W'(3) : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with valid/ready handshake on both sides.
// One bit is shifted per cycle; result and significant-digit count are registered on the last shift.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 4,
  localparam int unsigned BCD_W  = DIGIT_W * DIGITS,
  localparam int unsigned NDIG_W = $clog2(DIGITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [BIN_W-1:0]  in_bin_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [BCD_W-1:0]  out_bcd_o,
  output logic [NDIG_W-1:0] out_ndig_o
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  if (BIN_W == 0 || BIN_W > 32) begin : g_bad_bin_w
    $error("bin_to_bcd_seq: BIN_W must be in 1..32");
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  shreg_q, shreg_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  out_bcd_q, out_bcd_d;
  logic [NDIG_W-1:0] out_ndig_q, out_ndig_d;

  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W-1:0]       bcd_shl;
  logic [BIN_W-1:0]       shreg_shl;
  logic [BCD_W+BIN_W:0]   cat_shl;
  logic [NDIG_W-1:0]      ndig_shl;
  logic                   unused_top_bit;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_add3_digit u_add3 (
      .d_i (bcd_q[DIGIT_W*k +: DIGIT_W]),
      .d_o (bcd_adj[DIGIT_W*k +: DIGIT_W])
    );
  end

  // The top bit shifted out of the BCD field is always zero given the DIGITS check.
  assign cat_shl        = {bcd_adj, shreg_q, 1'b0};
  assign bcd_shl        = cat_shl[BIN_W +: BCD_W];
  assign shreg_shl      = cat_shl[BIN_W-1:0];
  assign unused_top_bit = cat_shl[BCD_W+BIN_W];

  always_comb begin
    ndig_shl = NDIG_W'(1);
    for (int unsigned k = 1; k < DIGITS; k++) begin
      if (bcd_shl[DIGIT_W*k +: DIGIT_W] != '0) begin
        ndig_shl = NDIG_W'(k + 1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    out_bcd_d  = out_bcd_q;
    out_ndig_d = out_ndig_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          shreg_d = in_bin_i;
          bcd_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = StShift;
        end
      end
      StShift: begin
        shreg_d = shreg_shl;
        bcd_d   = bcd_shl;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = StDone;
          out_bcd_d  = bcd_shl;
          out_ndig_d = ndig_shl;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shreg_q    <= '0;
      bcd_q      <= '0;
      out_bcd_q  <= '0;
      out_ndig_q <= NDIG_W'(1);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      bcd_q      <= bcd_d;
      out_bcd_q  <= out_bcd_d;
      out_ndig_q <= out_ndig_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign out_bcd_o   = out_bcd_q;
  assign out_ndig_o  = out_ndig_q;

endmodule
